// File: rtl/ft232h_tx_stream.sv
// Transmit stage for the FT232H 245-style synchronous FIFO port.
// Buffers a user byte stream and strobes it out at up to one byte per clock, with optional send-immediate.
module ft232h_tx_stream #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [ADDR_W:0]   level,
  input  logic              txe_n,
  output logic              wr_n,
  output logic [7:0]        data,
  output logic              oe_n,
  output logic              rd_n,
  output logic              siwu_n
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PULSE
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_wr_n;
  logic [7:0]        r_data;
  logic              r_siwu_n;
  state_t            r_state;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_level_next;
  logic [ADDR_W-1:0] w_rd_ptr_next;
  logic              w_write_through;
  state_t            w_state_next;

  assign in_ready = ~rst & (r_level < FULL_LEVEL);
  assign w_push   = in_valid & in_ready;
  // The chip takes the offered byte on any edge where our strobe is low and it reports space.
  assign w_pop    = ~r_wr_n & ~txe_n;

  assign w_level_next  = r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
  assign w_rd_ptr_next = r_rd_ptr + ADDR_W'(w_pop);
  // Nothing left in memory after the pop, so the incoming byte becomes the new head directly.
  assign w_write_through = w_push & (r_level == (ADDR_W+1)'(w_pop));

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_wr_n   <= 1'b1;
      r_data   <= 8'h00;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_level  <= w_level_next;
      r_wr_n   <= ~(~txe_n & (w_level_next != '0));
      if (w_level_next != '0) begin
        r_data <= w_write_through ? in_data : r_mem[w_rd_ptr_next];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (flush) w_state_next = ST_WAIT;
      ST_WAIT:  if ((r_level == '0) && r_wr_n) w_state_next = ST_PULSE;
      ST_PULSE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_siwu_n <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_siwu_n <= (w_state_next != ST_PULSE);
    end
  end

  assign level  = r_level;
  assign wr_n   = r_wr_n;
  assign data   = r_data;
  assign siwu_n = r_siwu_n;
  assign oe_n   = 1'b1;
  assign rd_n   = 1'b1;

endmodule
